// File: rtl/cpu_ctrl_mem_unit.sv
// Control decode, immediate sign-extension and byte-wide data memory for the 8-bit teaching CPU.
// Optional build macro DMEM_READ_GATE_EN forces ReadData to zero unless the decoded MemRead is set.
module cpu_ctrl_mem_unit #(
  parameter int DEPTH = 32
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [1:0] opcode,
  input  logic [1:0] imm,
  input  logic [7:0] Address,
  input  logic [7:0] WriteData,
  output logic [7:0] Control,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrc,
  output logic       Branch,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       ALUOp,
  output logic [7:0] ExtendedValue,
  output logic [7:0] ReadData
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    control_s;
  logic [AW-1:0] index_s;
  logic [7:0]    mem_word_s;
  logic [7:0]    read_data_s;
  logic [7:0]    mem_r [DEPTH];
  logic          unused_s;

  // Opcode decode; unknown opcodes fall to the default and assert nothing
  always_comb begin
    control_s = 8'h00;
    case (opcode)
      2'b00:   control_s = 8'hC1;
      2'b01:   control_s = 8'h6A;
      2'b10:   control_s = 8'h24;
      2'b11:   control_s = 8'h10;
      default: control_s = 8'h00;
    endcase
  end

  assign Control  = control_s;
  assign RegDst   = control_s[7];
  assign RegWrite = control_s[6];
  assign ALUSrc   = control_s[5];
  assign Branch   = control_s[4];
  assign MemRead  = control_s[3];
  assign MemWrite = control_s[2];
  assign MemtoReg = control_s[1];
  assign ALUOp    = control_s[0];

  assign ExtendedValue = {{6{imm[1]}}, imm};

  // Upper address bits are deliberately ignored so the memory aliases modulo DEPTH
  assign index_s    = Address[AW-1:0];
  assign mem_word_s = mem_r[index_s];
  assign unused_s   = ^{Address >> AW, control_s[3]};

  // Memory update: reset loads mem[i]=i and wins over a store on the same edge
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'(i);
      end
    end else if (control_s[2]) begin
      mem_r[index_s] <= WriteData;
    end else begin
      mem_r[index_s] <= mem_r[index_s];
    end
  end

  // Asynchronous read path, optionally gated by the decoded MemRead strobe
  always_comb begin
    read_data_s = 8'h00;
`ifdef DMEM_READ_GATE_EN
    if (control_s[3]) begin
      read_data_s = mem_word_s;
    end else begin
      read_data_s = 8'h00;
    end
`else
    read_data_s = mem_word_s;
`endif
  end

  assign ReadData = read_data_s;

endmodule

// File: tb/tb_cpu_ctrl_mem_unit.sv
// Self-checking bench for cpu_ctrl_mem_unit: behavioural model compared every cycle plus directed literal checks.
module tb_cpu_ctrl_mem_unit;

  localparam int DEPTH = 32;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic [1:0] opcode = 2'b00;
  logic [1:0] imm = 2'b00;
  logic [7:0] Address = 8'h00;
  logic [7:0] WriteData = 8'h00;
  logic [7:0] Control;
  logic       RegDst, RegWrite, ALUSrc, Branch, MemRead, MemWrite, MemtoReg, ALUOp;
  logic [7:0] ExtendedValue;
  logic [7:0] ReadData;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_ctrl_mem_unit #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .imm(imm),
    .Address(Address), .WriteData(WriteData), .Control(Control),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .Branch(Branch),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .ALUOp(ALUOp),
    .ExtendedValue(ExtendedValue), .ReadData(ReadData)
  );

  always #5 CLK = ~CLK;

  // Model: memory as a plain byte array, control as named instruction properties
  byte unsigned model_mem [DEPTH];
  bit           model_init = 1'b0;

  function automatic logic [7:0] model_control(input logic [1:0] op);
    bit is_add, is_lw, is_sw, is_j;
    is_add = (op == 2'd0); is_lw = (op == 2'd1);
    is_sw  = (op == 2'd2); is_j  = (op == 2'd3);
    // RegDst RegWrite ALUSrc Branch MemRead MemWrite MemtoReg ALUOp
    return {is_add, is_add | is_lw, is_lw | is_sw, is_j, is_lw, is_sw, is_lw, is_add};
  endfunction

  function automatic logic [7:0] model_read(input logic [1:0] op, input logic [7:0] ad);
    logic [7:0] v;
    v = model_mem[int'(ad) % DEPTH];
`ifdef DMEM_READ_GATE_EN
    if (op != 2'd1) v = 8'h00;
`endif
    return v;
  endfunction

  always @(posedge CLK) begin
    if (Reset == 1'b0) begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] <= byte'(i);
      model_init <= 1'b1;
    end else if (opcode == 2'd2) begin
      model_mem[int'(Address) % DEPTH] <= WriteData;
    end
  end

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge
  always @(negedge CLK) begin
    check8("control", Control, model_control(opcode));
    check8("strobes", {RegDst, RegWrite, ALUSrc, Branch, MemRead, MemWrite, MemtoReg, ALUOp},
           model_control(opcode));
    check8("extend", ExtendedValue, 8'(int'($signed(imm))));
    if (model_init) check8("readdata", ReadData, model_read(opcode, Address));
  end

  task automatic drive(input logic rs, input logic [1:0] op, input logic [1:0] im,
                       input logic [7:0] ad, input logic [7:0] wd);
    @(posedge CLK);
    #2;
    Reset = rs; opcode = op; imm = im; Address = ad; WriteData = wd;
  endtask

  logic [7:0] exp_ctl [4];
  logic [7:0] exp_ext [4];

  initial begin
    exp_ctl = '{8'hC1, 8'h6A, 8'h24, 8'h10};
    exp_ext = '{8'h00, 8'h01, 8'hFE, 8'hFF};

    // Decode and extender sweeps (independent of reset)
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'(k), 2'(k), 8'h00, 8'h00);
      @(negedge CLK); #1;
      check8("lit_control", Control, exp_ctl[k]);
      check8("lit_memwrite", {7'b0, MemWrite}, {7'b0, exp_ctl[k][2]});
      check8("lit_extend", ExtendedValue, exp_ext[k]);
    end

    // Reset init and address sweep
    drive(1'b0, 2'b01, 2'b00, 8'h00, 8'h00);
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b1, 2'b01, 2'b00, 8'(a), 8'h00);
      @(negedge CLK); #1;
      check8("lit_init", ReadData, 8'(a));
    end
    drive(1'b1, 2'b01, 2'b00, 8'h25, 8'h00);
    @(negedge CLK); #1;
    check8("lit_wrap", ReadData, 8'h05);

    // Store then load, with aliasing
    drive(1'b1, 2'b10, 2'b00, 8'h07, 8'hA5);
    drive(1'b1, 2'b01, 2'b00, 8'h07, 8'h00);
    @(negedge CLK); #1;
    check8("lit_load", ReadData, 8'hA5);
    drive(1'b1, 2'b01, 2'b00, 8'h27, 8'h00);
    @(negedge CLK); #1;
    check8("lit_alias", ReadData, 8'hA5);
    drive(1'b1, 2'b01, 2'b00, 8'h08, 8'h00);
    @(negedge CLK); #1;
    check8("lit_neighbour", ReadData, 8'h08);

    // Same-cycle store/read: old value before the edge, new one after
    drive(1'b1, 2'b10, 2'b00, 8'h09, 8'h3C);
    @(negedge CLK); #1;
`ifdef DMEM_READ_GATE_EN
    check8("lit_pre_store", ReadData, 8'h00);
`else
    check8("lit_pre_store", ReadData, 8'h09);
`endif
    @(posedge CLK); #1;
`ifndef DMEM_READ_GATE_EN
    check8("lit_post_store", ReadData, 8'h3C);
`endif
    #1;
    opcode = 2'b01;

    // Non-store opcodes must not write
    drive(1'b1, 2'b00, 2'b00, 8'h03, 8'hFF);
    drive(1'b1, 2'b01, 2'b00, 8'h03, 8'hFF);
    drive(1'b1, 2'b11, 2'b00, 8'h03, 8'hFF);
    drive(1'b1, 2'b01, 2'b00, 8'h03, 8'hFF);
    @(negedge CLK); #1;
    check8("lit_nostore", ReadData, 8'h03);

    // Reset wins over a simultaneous store
    drive(1'b0, 2'b10, 2'b00, 8'h04, 8'h5A);
    drive(1'b1, 2'b01, 2'b00, 8'h04, 8'h00);
    @(negedge CLK); #1;
    check8("lit_collision", ReadData, 8'h04);
    drive(1'b1, 2'b00, 2'b00, 8'h04, 8'h00);
    @(negedge CLK); #1;
`ifdef DMEM_READ_GATE_EN
    check8("lit_gate", ReadData, 8'h00);
`else
    check8("lit_ungated", ReadData, 8'h04);
`endif
    drive(1'b1, 2'b01, 2'b00, 8'h07, 8'h00);
    @(negedge CLK); #1;
    check8("lit_reinit", ReadData, 8'h07);

    // Multi-cycle reset after stores behaves like a single one
    drive(1'b1, 2'b10, 2'b00, 8'h1F, 8'h77);
    drive(1'b0, 2'b10, 2'b00, 8'h1F, 8'h66);
    drive(1'b0, 2'b00, 2'b00, 8'h1F, 8'h00);
    drive(1'b1, 2'b01, 2'b00, 8'h1F, 8'h00);
    @(negedge CLK); #1;
    check8("lit_long_reset", ReadData, 8'h1F);

    drive(1'b1, 2'b01, 2'b00, 8'h00, 8'h00);
    @(negedge CLK); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
